// File: rtl/instr_fetch_if.sv
// Instruction-fetch bundle: the memory-side request/ack pair, the redirect
// port from the branch unit and the instruction handshake towards decode.
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_ready;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [6:0]  opcode;

   // Fetch unit side
   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, opcode,
      input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
   );

   // Environment side (memory, branch unit, decode)
   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, opcode,
      output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Single-entry instruction fetch stage. Issues one word fetch at a time,
// holds the returned instruction until decode takes it, and handles
// redirects by dropping any in-flight request instead of cancelling it,
// since the memory cannot abort an access once it has been requested.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic            clk,
   input logic            rst,
   instr_fetch_if.master  bus
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,   // request outstanding at pc
      HOLD  = 2'd1,   // instruction parked for decode, no request
      DROP  = 2'd2    // stale request at req_addr must finish, result ignored
   } state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        valid_q, valid_d;
   logic [31:0] target;

   // Redirect targets are forced onto a word boundary.
   assign target = {bus.redirect_pc[31:2], 2'b00};

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         instr_q    <= NOP_INSTR;
         instr_pc_q <= 32'h0000_0000;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
      end
   end

   // Next-state and next-datapath logic; redirect outranks every other event.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      case (state_q)
         FETCH: begin
            if (bus.redirect) begin
               pc_d = target;
               // Without an ack the old request is still on the bus and
               // must be allowed to finish at its original address.
               if (!bus.imem_ack) begin
                  req_addr_d = pc_q;
                  state_d    = DROP;
               end
            end else if (bus.imem_ack) begin
               instr_d    = bus.imem_rdata;
               instr_pc_d = pc_q;
               valid_d    = 1'b1;
               pc_d       = pc_q + 32'd4;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            // Any ack seen here is ignored; no request is outstanding.
            if (bus.redirect) begin
               valid_d = 1'b0;
               pc_d    = target;
               state_d = FETCH;
            end else if (bus.instr_ready) begin
               valid_d = 1'b0;
               state_d = FETCH;
            end
         end
         DROP: begin
            if (bus.redirect) begin
               pc_d = target;
            end
            if (bus.imem_ack) begin
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
            valid_d = 1'b0;
         end
      endcase
   end

   // Output decode; everything is forced to its idle value while in reset.
   always_comb begin
      bus.imem_req    = 1'b0;
      bus.imem_addr   = pc_q;
      bus.instr_valid = 1'b0;
      bus.instr       = NOP_INSTR;
      bus.instr_pc    = 32'h0000_0000;
      bus.opcode      = 7'b000_0000;
      if (!rst) begin
         bus.imem_req    = (state_q != HOLD);
         bus.imem_addr   = (state_q == DROP) ? req_addr_q : pc_q;
         bus.instr_valid = valid_q;
         bus.instr       = instr_q;
         bus.instr_pc    = instr_pc_q;
         // A zero opcode lands in the controller's default case, so no
         // register or memory write can happen without a valid instruction.
         bus.opcode      = valid_q ? instr_q[6:0] : 7'b000_0000;
      end
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-006 Port imem_addr, output, 32 bits: fetch address, word-aligned.
REQ-007 Port imem_ack, input, 1 bit: memory has returned data for the current request.
REQ-008 Port imem_rdata, input, 32 bits: instruction word; valid only while imem_ack=1.
REQ-009 Port redirect, input, 1 bit: branch/jump redirect request.
REQ-010 Port redirect_pc, input, 32 bits: redirect target.
REQ-011 Port instr_ready, input, 1 bit: decode stage accepts the held instruction.
REQ-012 Port instr_valid, output, 1 bit: instr, instr_pc and opcode are valid.
REQ-013 Port instr, output, 32 bits: fetched instruction.
REQ-014 Port instr_pc, output, 32 bits: address of instr.
REQ-015 Port opcode, output, 7 bits: drives the main controller's opcode input.

Function
REQ-016 The block SHALL implement three states:
- FETCH: request outstanding
- HOLD: instruction held for decode
- DROP: outstanding request must complete, then be discarded
REQ-017 Internal registers SHALL be pc (next fetch address) and req_addr (address of the outstanding request).
REQ-018 imem_req SHALL be 1 in FETCH and DROP, 0 in HOLD, and 0 while rst=1.
REQ-019 imem_addr SHALL equal pc in FETCH and req_addr in DROP. Once asserted, imem_req and imem_addr SHALL stay stable until the cycle imem_ack=1.
REQ-020 In FETCH with imem_ack=1 and redirect=0, the block SHALL, in the next cycle:
- capture instr=imem_rdata and instr_pc=pc
- set instr_valid=1 and pc=pc+4
- enter HOLD
Latency is one cycle from ack to instr_valid.
REQ-021 pc arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
REQ-022 In HOLD, instr, instr_pc and instr_valid SHALL remain stable while instr_ready=0.
REQ-023 In HOLD with instr_ready=1 and redirect=0, the block SHALL clear instr_valid next cycle and enter FETCH, giving a 1-cycle request gap.
REQ-024 redirect SHALL have priority over every other event.
REQ-025 redirect_pc[1:0] SHALL be forced to 2'b00 on capture.
REQ-026 redirect in FETCH with imem_ack=0: req_addr=pc, pc=redirect_pc, enter DROP, instr_valid stays 0.
REQ-027 redirect in FETCH with imem_ack=1: discard imem_rdata, pc=redirect_pc, stay in FETCH, instr_valid stays 0.
REQ-028 redirect in HOLD: instr_valid=0 next cycle, pc=redirect_pc, enter FETCH, even if instr_ready=1 in the same cycle (the instruction is flushed).
REQ-029 redirect in DROP: pc=redirect_pc (latest target wins); stay in DROP unless imem_ack=1, in which case enter FETCH.
REQ-030 In DROP with imem_ack=1, the block SHALL discard the data and enter FETCH with imem_addr=pc next cycle.
REQ-031 opcode SHALL equal instr[6:0] when instr_valid=1, else 7'b0000000, so the controller's default case suppresses register and memory writes.
REQ-032 imem_ack received in HOLD SHALL be ignored.

Reset
REQ-033 While rst=1, the block SHALL hold all outputs at reset values: imem_req=0, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0, opcode=0.
REQ-034 The reset values of internal state SHALL be: state=FETCH, pc=RESET_PC, req_addr=RESET_PC.
REQ-035 rst asserted in any state, including DROP with a request outstanding, SHALL abandon that request. The block SHALL take no action on a late imem_ack while rst=1.
REQ-036 In the first cycle after rst deasserts, imem_req=1 and imem_addr=RESET_PC.

Verification
REQ-037 Reset then ack one cycle later with rdata=32'h00500093 -> next cycle instr_valid=1, instr_pc=0, opcode=7'b0010011, imem_req=0.
REQ-038 Hold instr_ready=0 for 5 cycles in HOLD -> instr and instr_pc unchanged. Then instr_ready=1 -> next request at addr 32'h4 after a 1-cycle gap.
REQ-039 Redirect to 32'h0000_0102 in FETCH with ack delayed 3 cycles -> imem_addr stays at the old pc until ack, data discarded, next request at 32'h0000_0100.
REQ-040 Redirect plus instr_ready together in HOLD -> instr_valid=0 next cycle, next request at the redirect target, no instruction delivered.
REQ-041 RESET_PC=32'hFFFF_FFFC, ack the first fetch -> instr_pc=32'hFFFF_FFFC, next imem_addr=32'h0000_0000.
REQ-042 rst pulsed in DROP with ack arriving during rst -> after release, imem_addr=RESET_PC and instr_valid=0.
